// File: rtl/mem_responder.sv
// mem_responder: CPU word memory with power-on clear, streamed program load and 1-cycle registered reads
module mem_responder #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int LOAD_BASE  = 8,
  parameter bit LOAD_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] out,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  busy,
  output logic                  ld_overflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic [1:0] {CLEAR = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;
  state_t state, next;
  logic [ADDR_WIDTH-1:0] clr_ptr, ld_ptr, w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic xfer, w_en;
  always_ff @(posedge clk) state <= !rst_n ? CLEAR : next;
  always_comb begin
    next = state == CLEAR ? (&clr_ptr ? (LOAD_EN ? LOAD : RUN) : CLEAR) :
           state == LOAD  ? ((xfer && (ld_last || &ld_ptr)) ? RUN : LOAD) :
           state == RUN   ? RUN : CLEAR;
  end
  always_comb begin
    busy     = state == CLEAR || state == LOAD;
    ld_ready = state == LOAD;
  end
  // Single write port shared by clear, load and the CPU; reset never writes the array.
  always_comb begin
    xfer   = ld_valid && ld_ready;
    w_en   = rst_n && (state == CLEAR || xfer || (state == RUN && we));
    w_addr = state == CLEAR ? clr_ptr : state == LOAD ? ld_ptr : addr;
    w_data = state == CLEAR ? '0 : state == LOAD ? ld_data : data;
  end
  always_ff @(posedge clk) if (w_en) mem[w_addr] <= w_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_ptr     <= '0;
      ld_ptr      <= ADDR_WIDTH'(LOAD_BASE);
      out         <= '0;
      ld_overflow <= 1'b0;
    end else begin
      clr_ptr <= state == CLEAR ? clr_ptr + 1'b1 : clr_ptr;
      ld_ptr  <= state == CLEAR ? ADDR_WIDTH'(LOAD_BASE) : xfer ? ld_ptr + 1'b1 : ld_ptr;
      out     <= state == RUN ? mem[addr] : '0;
      if (xfer && &ld_ptr && !ld_last) ld_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed + randomized checks of mem_responder against a word-array model
module tb_mem_responder;
  localparam int AW = 6, DW = 16, DEPTH = 64, BASE = 8;
  logic clk = 0, rst_n = 0, we = 0, ld_valid = 0, ld_last = 0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data = '0, ld_data = '0;
  logic [DW-1:0] out, out_nl;
  logic ld_ready, busy, ld_overflow, ld_ready_nl, busy_nl, ld_overflow_nl;
  int checks = 0, failures = 0;
  logic [DW-1:0] model [DEPTH];
  int ld_ptr;
  bit loaded, exp_ovf;
  always #5 clk = ~clk;
  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOAD_BASE(BASE), .LOAD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .data(data), .out(out),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .busy(busy), .ld_overflow(ld_overflow));
  mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOAD_BASE(BASE), .LOAD_EN(1'b0)) dut_nl (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .data(data), .out(out_nl),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready_nl),
    .busy(busy_nl), .ld_overflow(ld_overflow_nl));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic reset_and_clear;
    rst_n = 0; we = 0; ld_valid = 0; ld_last = 0;
    tick;
    rst_n = 1;
    foreach (model[i]) model[i] = '0;
    ld_ptr = BASE; loaded = 0; exp_ovf = 0;
    chk("rst_busy", busy, 1); chk("rst_ready", ld_ready, 0);
    chk("rst_out", out, 0); chk("rst_ovf", ld_overflow, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("clr_busy", busy, 1); chk("clr_ready", ld_ready, 0); chk("clr_out", out, 0);
      chk("clr_busy_nl", busy_nl, 1);
      we = 1'($urandom); addr = AW'($urandom); data = DW'($urandom);
      ld_valid = 1'($urandom);
      tick;
    end
    we = 0; ld_valid = 0;
    chk("load_ready", ld_ready, 1); chk("load_busy", busy, 1);
    chk("nl_busy", busy_nl, 0); chk("nl_ready", ld_ready_nl, 0);
    for (int i = 0; i < DEPTH; i++) chk("clr_mem", dut.mem[i], 0);
  endtask
  task automatic load_step(bit v, logic [DW-1:0] d, bit last);
    chk("ld_ready_on", ld_ready, 1);
    ld_valid = v; ld_data = d; ld_last = last;
    tick;
    ld_valid = 0; ld_last = 0;
    if (v) begin
      model[ld_ptr] = d;
      loaded = last || ld_ptr == DEPTH - 1;
      exp_ovf = !last && ld_ptr == DEPTH - 1;
      ld_ptr++;
    end
    chk("ld_busy", busy, loaded ? 0 : 1);
    chk("ld_ovf", ld_overflow, exp_ovf);
  endtask
  task automatic run_op(bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    logic [DW-1:0] exp;
    exp = model[a];
    if (w) model[a] = d;
    we = w; addr = a; data = d;
    tick;
    we = 0;
    chk("run_out", out, exp);
  endtask
  initial begin
    reset_and_clear;
    load_step(1, 16'h7100, 0);
    load_step(0, 16'h1234, 0);
    load_step(1, 16'h8100, 0);
    load_step(0, 16'h5678, 1);
    load_step(1, 16'h0000, 1);
    chk("t2_ready_off", ld_ready, 0);
    chk("t2_m8", dut.mem[8], 16'h7100);
    chk("t2_m9", dut.mem[9], 16'h8100);
    chk("t2_m10", dut.mem[10], 16'h0000);
    run_op(1, 5, 16'hBEEF);
    run_op(0, 5, 0);
    run_op(0, 8, 0);
    run_op(0, 9, 0);
    run_op(0, 10, 0);
    ld_valid = 1; ld_data = 16'hFFFF;
    run_op(0, 8, 0);
    ld_valid = 0;
    for (int i = 0; i < 60; i++) run_op(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
    for (int i = 0; i < DEPTH; i++) chk("run_mem", dut.mem[i], model[i]);
    reset_and_clear;
    for (int i = 0; i < 400 && !loaded; i++) load_step(1'($urandom), DW'($urandom), 0);
    chk("t5_done", loaded, 1);
    chk("t5_count", ld_ptr, DEPTH);
    chk("t5_ovf", ld_overflow, 1);
    chk("t5_busy", busy, 0);
    for (int i = 0; i < DEPTH; i++) chk("t5_mem", dut.mem[i], model[i]);
    for (int i = 0; i < 10; i++) run_op(0, AW'($urandom), 0);
    run_op(0, 63, 0);
    reset_and_clear;
    load_step(1, 16'hAAAA, 0);
    load_step(1, 16'h5555, 0);
    reset_and_clear;
    chk("t6_ovf", ld_overflow, 0);
    chk("t6_m8", dut.mem[8], 0);
    addr = 8;
    tick;
    chk("t6_nl_out", out_nl, 0);
    chk("t6_nl_busy", busy_nl, 0);
    chk("t6_busy", busy, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Target side of the CPU memory interface: DEPTH = 2^ADDR_WIDTH words of DATA_WIDTH bits.
- Services CPU reads with exactly one clock of latency and CPU writes in the same cycle.
- Before the CPU runs, it clears the whole array and then takes a program image over a valid/ready load stream.
- `busy` is high during clear and load; the top level holds the CPU in reset while it is high (`cpu rst_n = rst_n & ~busy`).

Parameters:
- ADDR_WIDTH, 6: address width; DEPTH = 2^ADDR_WIDTH.
- DATA_WIDTH, 16: word width.
- LOAD_BASE, 8: first address written by the load stream; matches the CPU initial PC.
- LOAD_EN, 1: 1 = LOAD phase after CLEAR; 0 = go straight from CLEAR to RUN.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- we  input  1  CPU write enable.
- addr  input  ADDR_WIDTH  CPU address.
- data  input  DATA_WIDTH  CPU write data.
- out  output  DATA_WIDTH  registered read data (CPU mem_in).
- ld_valid  input  1  load word valid.
- ld_data  input  DATA_WIDTH  load word.
- ld_last  input  1  marks final load word; qualified by transfer.
- ld_ready  output  1  loader may transfer.
- busy  output  1  high in CLEAR and LOAD.
- ld_overflow  output  1  sticky; load ran past the top address.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=CLEAR, clear pointer=0, out=0, ld_overflow=0, busy=1, ld_ready=0.
  - Array contents are not touched by reset itself; CLEAR overwrites them.
- CLEAR:
  - Each cycle writes mem[clr_ptr]=0, then clr_ptr+1.
  - The cycle that writes DEPTH-1 moves to LOAD (LOAD_EN=1) or RUN (LOAD_EN=0).
  - Lasts exactly DEPTH cycles. CPU port ignored; out held at 0.
- LOAD:
  - ld_ready=1 combinationally while in LOAD.
  - Transfer = ld_valid & ld_ready. On transfer: mem[ld_ptr]=ld_data, ld_ptr+1.
  - ld_ptr is loaded with LOAD_BASE on entry to LOAD.
  - Transfer with ld_last=1 → RUN next cycle.
  - Transfer at ld_ptr=DEPTH-1 with ld_last=0 → stores the word, sets ld_overflow=1, → RUN. Never wraps to 0.
  - No transfer: state held indefinitely. ld_valid may toggle freely.
  - CPU port ignored; out held at 0.
- RUN:
  - busy=0, ld_ready=0; load inputs ignored.
  - Every cycle: out <= mem[addr] (read-before-write).
  - If we=1: mem[addr] <= data in the same edge.
  - Write and read at the same address in one cycle: out returns the OLD word; the new word is visible on the following read.
  - Address space is full; no out-of-range case.
  - RUN is left only by reset.
- Transition cycle: the first edge in RUN already services the CPU port. busy falls on that same edge, so the CPU leaves reset the following cycle.
- Reset mid-operation (any state, including mid-LOAD or RUN): the synchronous reset returns to CLEAR and the full clear plus reload repeats. ld_overflow clears.
- State encoding: CLEAR, LOAD, RUN (2 bits; the 4th code is illegal and goes to CLEAR).
- Pointers are ADDR_WIDTH bits; the CLEAR terminal is detected on clr_ptr == DEPTH-1, not by overflow.

Test Plan:
1. Reset, LOAD_EN=1, ld_valid=0: busy=1 for 64 cycles, then ld_ready=1. Check out=0 throughout, and mem[0..63] all 0 via backdoor.
2. Load 3 words 0x7100, 0x8100, 0x0000 (last on third), ld_valid toggled 1/0/1/0/1:
   - Words land at addresses 8, 9, 10.
   - busy falls the cycle after the third transfer; ld_overflow=0.
3. RUN: write 0xBEEF to addr 5 with we=1 while reading addr 5 in the same cycle → out = old value 0x0000. Next cycle, read addr 5 → out=0xBEEF.
4. RUN back-to-back reads at addr 8, 9, 10 on consecutive cycles → out = 0x7100, 0x8100, 0x0000, each one cycle after its address.
5. Load 56 words from 8 with ld_last never asserted:
   - 56th transfer writes addr 63, ld_overflow=1, → RUN.
   - mem[0..7] remain 0.
6. Assert rst_n=0 for one cycle during LOAD after 2 transfers → busy=1, CLEAR repeats (64 cycles), addr 8 reads 0 after the reload ends with no words sent (LOAD_EN=0 variant: RUN straight after 64 cycles).
